sponge_padder: RTL
==================

Name: sponge_padder

Overview:
- Parametrised successor to the fixed SHA3-512 padder.
- Accepts message words of IN_W bits and packs them into one RATE_BITS-wide rate block.
- Applies Keccak multi-rate padding (domain suffix, pad10*1) and hands the block to f_permutation through a ready/ack handshake.
- Rate (SHA3-224/256/384/512, SHAKE128/256) and word width are build-time parameters; it sits between the message source and the Keccak permutation inside the Kyber hash/XOF wrappers.

Parameters:
- IN_W, 64, input word width in bits; multiple of 8, at least 16.
- RATE_BITS, 576, sponge rate in bits; multiple of IN_W. 576 = SHA3-512, 1088 = SHA3-256/SHAKE256, 1344 = SHAKE128.
- Derived constants: WORDS = RATE_BITS/IN_W; BN_W = $clog2(IN_W/8).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in  in  IN_W  message word; first byte in the MSBs.
- in_ready  in  1  in is valid this cycle.
- is_last  in  1  qualifies in as the final word of the message.
- byte_num  in  BN_W  valid bytes in the final word, 0..IN_W/8-1; sampled only with is_last.
- mode  in  1  0 = SHA3 (suffix 8'h06), 1 = SHAKE (suffix 8'h1F); sampled with the first word of each message.
- restart  in  1  single-cycle pulse; returns DONE to IDLE.
- f_ack  in  1  permutation has consumed out.
- buffer_full  out  1  no word accepted this cycle.
- out  out  RATE_BITS  rate block; slot 0 in out[RATE_BITS-1 -: IN_W].
- out_ready  out  1  out holds a complete block.
- out_last  out  1  the block in out is the final, padded block.

Behaviour:
- Reset (asynchronous on reset low): out=0, out_ready=0, out_last=0, buffer_full=0, slot counter=0, state=IDLE.
- States: IDLE, ABSORB, PAD, FULL, DONE.
- Accept condition: in_ready && !buffer_full.
  - buffer_full = (state==PAD || state==FULL || state==DONE).
  - An accepted word is written to slot[cnt] on that edge; cnt increments.
- IDLE:
  - An accepted word latches mode, writes slot 0, and moves to ABSORB.
  - If that word also has is_last, it is handled as in ABSORB.
- ABSORB, non-last word:
  - If this write fills slot WORDS-1, go to FULL with out_ready=1 and out_last=0.
- ABSORB, is_last word:
  - Slot gets the top byte_num bytes of in, then the suffix byte, then zeros.
  - byte_num=0 means in is ignored entirely.
  - If the slot is not WORDS-1, go to PAD; otherwise go to FULL with out_last=1.
  - The last word always fits, because it carries fewer than IN_W/8 bytes.
- PAD:
  - Writes one all-zero slot per cycle.
  - The write of slot WORDS-1 also sets that slot's LSB byte |= 8'h80, moves to FULL, and sets out_ready=1 and out_last=1 on that same edge.
  - If the suffix already lies in the LSB byte of slot WORDS-1, that byte becomes 8'h86 (SHA3) or 8'h9F (SHAKE).
- FULL:
  - Holds out stable until f_ack.
  - On f_ack: out_ready=0, out cleared, cnt=0; go to DONE if out_last, else ABSORB. out_last clears on the same edge.
  - No word is accepted on the f_ack edge.
- DONE:
  - All inputs except restart are ignored.
  - restart moves to IDLE next edge; restart in other states is ignored.
- f_ack outside FULL is ignored.
- A PAD-to-FULL transition takes priority over a coincident restart.
- Latency: an is_last word accepted into slot k gives out_ready exactly WORDS-1-k edges later; 0 when k = WORDS-1.

Optional Feature:
- SPONGE_PADDER_XOF_EN defined: mode selects SHA3 or SHAKE as above.
- Undefined: mode port remains but is ignored, suffix is fixed at 8'h06, and no mode register is synthesised.

Decomposition:
- Shared package keccak_pkg holds:
  - SUFFIX_SHA3 = 8'h06, SUFFIX_SHAKE = 8'h1F, PAD_END = 8'h80;
  - the state enum;
  - rate constants RATE_SHA3_512 = 576, RATE_SHA3_256 = 1088, RATE_SHAKE128 = 1344.
- One sub-module, sponge_pad_word (combinational): given in, byte_num and suffix, produces the padded last word.

Test Plan (IN_W=64, RATE_BITS=576):
- 64'hfc7b8cdafc7b8cda, then is_last with byte_num=0, mode=0 -> out[575:512] = fc7b8cdafc7b8cda; out[511:504] = 06; out[7:0] = 80; all other bits 0; out_ready rises 7 edges after the is_last edge; out_last=1.
- Nine non-last words 64'h0101..., 64'h0202..., ... 64'h0909... -> out_ready=1, out_last=0, out is their concatenation. f_ack, then is_last with byte_num=0 -> second block is 06 followed by zeros and ending 80, with out_last=1.
- Eight words, then is_last with in=64'h1122334455667788 and byte_num=7, mode=1, XOF enabled -> slot 8 = 112233445566779F; out_ready on the same edge.
- Same stimulus with mode=0 -> slot 8 ends in 86. With XOF undefined and mode=1 -> slot 8 still ends in 86.
- in_ready held high during PAD and FULL -> no word is written; f_ack and in_ready in the same cycle -> word accepted only on the following edge.
- reset pulled low mid-ABSORB (after 3 words) -> all outputs 0 immediately. restart in DONE -> IDLE; a new 1-word message pads correctly.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak sponge constants, the padder state encoding and the domain-suffix selector.
package keccak_pkg;

  localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END      = 8'h80;

  localparam int RATE_SHA3_512 = 576;
  localparam int RATE_SHA3_256 = 1088;
  localparam int RATE_SHAKE128 = 1344;

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    PAD,
    FULL,
    DONE
  } pad_state_e;

  function automatic logic [7:0] domain_suffix(input logic shake);
    return shake ? SUFFIX_SHAKE : SUFFIX_SHA3;
  endfunction

endpackage

// File: rtl/sponge_padder_if.sv
// Message-source / permutation handshake bundle for sponge_padder.
interface sponge_padder_if #(
  parameter int IN_W      = 64,
  parameter int RATE_BITS = 576
);
  localparam int BN_W = $clog2(IN_W/8);

  logic [IN_W-1:0]      in;
  logic                 in_ready;
  logic                 is_last;
  logic [BN_W-1:0]      byte_num;
  logic                 mode;
  logic                 restart;
  logic                 f_ack;
  logic                 buffer_full;
  logic [RATE_BITS-1:0] out;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    output in, in_ready, is_last, byte_num, mode, restart, f_ack,
    input  buffer_full, out, out_ready, out_last
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, mode, restart, f_ack,
    output buffer_full, out, out_ready, out_last
  );

endinterface

// File: rtl/sponge_pad_word.sv
// Builds the final message word: top byte_num bytes of the input, then the suffix, then zeros.
module sponge_pad_word #(
  parameter int  IN_W = 64,
  localparam int BN_W = $clog2(IN_W/8)
) (
  input  logic [IN_W-1:0] in_i,
  input  logic [BN_W-1:0] byte_num_i,
  input  logic [7:0]      suffix_i,
  output logic [IN_W-1:0] word_o
);

  localparam int NB = IN_W/8;

  always_comb begin
    word_o = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(byte_num_i))
        word_o[IN_W-1-8*i -: 8] = in_i[IN_W-1-8*i -: 8];
      else if (i == int'(byte_num_i))
        word_o[IN_W-1-8*i -: 8] = suffix_i;
    end
  end

endmodule

// File: rtl/sponge_padder.sv
// Packs IN_W-bit message words into one rate block with Keccak pad10*1 padding.
// Define SPONGE_PADDER_XOF_EN to let the mode input select the SHAKE domain suffix.
module sponge_padder
  import keccak_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int RATE_BITS = RATE_SHA3_512
) (
  input logic             clk,
  input logic             reset,
  sponge_padder_if.slave  bus
);

  localparam int WORDS = RATE_BITS/IN_W;
  localparam int CNT_W = $clog2(WORDS+1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS-1);

  pad_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [RATE_BITS-1:0] out_q;
  logic                 out_ready_q;
  logic                 out_last_q;

  logic                 busy;
  logic                 accept;
  logic                 at_last_slot;
  logic [7:0]           suffix;
  logic [IN_W-1:0]      pad_word;
  logic [IN_W-1:0]      slot_d;
  int                   slot_lsb;

  assign busy         = (state_q == PAD) || (state_q == FULL) || (state_q == DONE);
  assign accept       = bus.in_ready && !busy;
  assign at_last_slot = (cnt_q == LAST_SLOT);
  assign slot_lsb     = (WORDS - 1 - int'(cnt_q)) * IN_W;

`ifdef SPONGE_PADDER_XOF_EN
  logic mode_q;

  // The first word of a message may also be its last, so IDLE uses the live mode bit.
  assign suffix = domain_suffix((state_q == IDLE) ? bus.mode : mode_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mode_q <= 1'b0;
    else if (state_q == IDLE && accept)
      mode_q <= bus.mode;
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign suffix      = SUFFIX_SHA3;
`endif

  sponge_pad_word #(.IN_W(IN_W)) u_pad_word (
    .in_i       (bus.in),
    .byte_num_i (bus.byte_num),
    .suffix_i   (suffix),
    .word_o     (pad_word)
  );

  // The closing 1 of pad10*1 lands in the LSB byte of the final slot, possibly on top of the suffix.
  always_comb begin
    slot_d = '0;
    if (state_q == IDLE || state_q == ABSORB)
      slot_d = bus.is_last ? pad_word : bus.in;
    if (at_last_slot && (state_q == PAD ||
        ((state_q == IDLE || state_q == ABSORB) && bus.is_last)))
      slot_d[7:0] = slot_d[7:0] | PAD_END;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= '0;
      out_ready_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ABSORB: begin
          if (accept) begin
            out_q[slot_lsb +: IN_W] <= slot_d;
            cnt_q                   <= cnt_q + CNT_W'(1);
            if (at_last_slot) begin
              state_q     <= FULL;
              out_ready_q <= 1'b1;
              out_last_q  <= bus.is_last;
            end else begin
              state_q <= bus.is_last ? PAD : ABSORB;
            end
          end
        end
        PAD: begin
          out_q[slot_lsb +: IN_W] <= slot_d;
          cnt_q                   <= cnt_q + CNT_W'(1);
          if (at_last_slot) begin
            state_q     <= FULL;
            out_ready_q <= 1'b1;
            out_last_q  <= 1'b1;
          end
        end
        FULL: begin
          if (bus.f_ack) begin
            out_q       <= '0;
            cnt_q       <= '0;
            out_ready_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= out_last_q ? DONE : ABSORB;
          end
        end
        DONE: begin
          if (bus.restart)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.buffer_full = busy;
  assign bus.out         = out_q;
  assign bus.out_ready   = out_ready_q;
  assign bus.out_last    = out_last_q;

endmodule
